// File: rtl/pipe_hazard_ctrl.sv
// Load-use hazard control for a 5-stage pipeline: stall/flush generation, registered
// writeback forwarding and HLT drain sequencing. Define HAZ_STALL_CNT_EN to enable oStallCount.
`timescale 1ns/1ps
module pipe_hazard_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  iIdSr1,
   input  logic [3:0]  iIdSr2,
   input  logic        iIdUsesSr1,
   input  logic        iIdUsesSr2,
   input  logic        iIdHalt,
   input  logic [3:0]  iExDest,
   input  logic        iExWritesReg,
   input  logic [3:0]  iMemDest,
   input  logic        iMemWritesReg,
   input  logic        iBusStall,
   output logic        oStallF,
   output logic        oStallD,
   output logic        oFlushE,
   output logic [1:0]  oForward,
   output logic        oHalted,
   output logic [15:0] oStallCount,
   output logic [1:0]  oState
);

   typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} stateT;

   stateT      state;
   logic [1:0] drainCnt;
   logic       hazard;
   logic       hazStall;
   logic       notRun;
   logic [1:0] fwdNext;

   // R0 is hard-wired, so a zero destination never produces a dependency.
   assign hazard = ((iIdUsesSr1 && (iIdSr1 == iExDest)) ||
                    (iIdUsesSr2 && (iIdSr2 == iExDest))) &&
                   iExWritesReg && (iExDest != 4'd0);

   assign hazStall = rst_n && !iBusStall && (state == RUN) && hazard;
   assign notRun   = rst_n && (state != RUN);

   assign oStallF = iBusStall || hazStall || notRun;
   assign oStallD = iBusStall || hazStall || notRun;
   assign oFlushE = !iBusStall && (hazStall || notRun);
   assign oState  = state;

   always_comb begin
      fwdNext = 2'b00;
      if (!hazard) begin
         fwdNext[0] = iIdUsesSr1 && iMemWritesReg && (iMemDest != 4'd0) && (iIdSr1 == iMemDest);
         fwdNext[1] = iIdUsesSr2 && iMemWritesReg && (iMemDest != 4'd0) && (iIdSr2 == iMemDest);
      end
   end

   // A bus stall freezes forwarding, FSM state and drain progress together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         drainCnt <= 2'd0;
         oForward <= 2'b00;
         oHalted  <= 1'b0;
      end else if (!iBusStall) begin
         oForward <= fwdNext;
         case (state)
            RUN: begin
               if (iIdHalt && !hazard) begin
                  state    <= DRAIN;
                  drainCnt <= 2'd3;
               end
            end
            DRAIN: begin
               if (drainCnt == 2'd1) begin
                  state   <= HALTED;
                  oHalted <= 1'b1;
               end
               drainCnt <= drainCnt - 2'd1;
            end
            HALTED: begin
               oHalted <= 1'b1;
            end
            default: begin
               state    <= RUN;
               drainCnt <= 2'd0;
            end
         endcase
      end
   end

`ifdef HAZ_STALL_CNT_EN
   logic [15:0] stallCnt;

   // Counts only RUN-state hazard bubbles; bus and drain stalls are excluded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stallCnt <= 16'h0000;
      else if (hazStall && (stallCnt != 16'hFFFF))
         stallCnt <= stallCnt + 16'h0001;
   end

   assign oStallCount = stallCnt;
`else
   assign oStallCount = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl; registered outputs are scored through expected queues.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

`ifdef HAZ_STALL_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic [3:0]  iIdSr1, iIdSr2, iExDest, iMemDest;
   logic        iIdUsesSr1, iIdUsesSr2, iIdHalt, iExWritesReg, iMemWritesReg, iBusStall;
   logic        oStallF, oStallD, oFlushE, oHalted;
   logic [1:0]  oForward, oState;
   logic [15:0] oStallCount;

   int          nChecks = 0;
   int          nPass   = 0;
   int          hazCnt  = 0;
   logic [1:0]  expFwdQ[$];
   logic        expHaltQ[$];

   pipe_hazard_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .iIdSr1(iIdSr1), .iIdSr2(iIdSr2), .iIdUsesSr1(iIdUsesSr1), .iIdUsesSr2(iIdUsesSr2),
      .iIdHalt(iIdHalt), .iExDest(iExDest), .iExWritesReg(iExWritesReg),
      .iMemDest(iMemDest), .iMemWritesReg(iMemWritesReg), .iBusStall(iBusStall),
      .oStallF(oStallF), .oStallD(oStallD), .oFlushE(oFlushE), .oForward(oForward),
      .oHalted(oHalted), .oStallCount(oStallCount), .oState(oState)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkEq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      nChecks++;
      if (got === exp) nPass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic setIn(input logic [3:0] sr1, input logic [3:0] sr2, input logic u1,
                        input logic u2, input logic halt, input logic [3:0] exD,
                        input logic exW, input logic [3:0] memD, input logic memW,
                        input logic bus);
      iIdSr1 = sr1; iIdSr2 = sr2; iIdUsesSr1 = u1; iIdUsesSr2 = u2; iIdHalt = halt;
      iExDest = exD; iExWritesReg = exW; iMemDest = memD; iMemWritesReg = memW;
      iBusStall = bus;
   endtask

   // One cycle: combinational outputs at negedge, registered outputs popped after posedge.
   task automatic tick(input logic expStall, input logic expFlush,
                       input logic [1:0] expFwd, input logic expHalt);
      expFwdQ.push_back(expFwd);
      expHaltQ.push_back(expHalt);
      @(negedge clk);
      checkEq("stallF", 16'(oStallF), 16'(expStall));
      checkEq("stallD", 16'(oStallD), 16'(expStall));
      checkEq("flushE", 16'(oFlushE), 16'(expFlush));
      @(posedge clk);
      #1;
      checkEq("forward", 16'(oForward), 16'(expFwdQ.pop_front()));
      checkEq("halted", 16'(oHalted), 16'(expHaltQ.pop_front()));
   endtask

   task automatic checkCount(input string tag);
      checkEq(tag, oStallCount, CNT_EN ? 16'(hazCnt) : 16'h0000);
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      #1;
      checkEq("rst_fwd", 16'(oForward), 16'h0);
      checkEq("rst_halted", 16'(oHalted), 16'h0);
      checkEq("rst_count", oStallCount, 16'h0);
      checkEq("rst_state", 16'(oState), 16'h0);
      hazCnt = 0;
      setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0] mFwd;
      logic       mHaz;
      rst_n = 1'b0;
      // Reset with a live hazard on the inputs: stalls stay low unless the bus stalls.
      setIn(3, 0, 1, 0, 0, 3, 1, 3, 1, 0);
      #2;
      checkEq("rst_stallF", 16'(oStallF), 16'h0);
      checkEq("rst_flushE", 16'(oFlushE), 16'h0);
      iBusStall = 1'b1;
      #1;
      checkEq("rst_bus_stallD", 16'(oStallD), 16'h1);
      checkEq("rst_bus_flushE", 16'(oFlushE), 16'h0);
      doReset();

      // EX writes R3, ID reads R3: one bubble, then forward from MEM.
      setIn(3, 0, 1, 0, 0, 3, 1, 0, 0, 0); tick(1, 1, 2'b00, 0); hazCnt++;
      setIn(3, 0, 1, 0, 0, 0, 0, 3, 1, 0); tick(0, 0, 2'b01, 0);
      checkCount("cnt_after_r3");
      // MEM writes R5 for both operands.
      setIn(5, 5, 1, 1, 0, 7, 1, 5, 1, 0); tick(0, 0, 2'b11, 0);
      // R0 never matches.
      setIn(0, 0, 1, 1, 0, 0, 1, 0, 1, 0); tick(0, 0, 2'b00, 0);
      // Sr2 hazard blocks forwarding even though MEM also matches.
      setIn(1, 9, 0, 1, 0, 9, 1, 9, 1, 0); tick(1, 1, 2'b00, 0); hazCnt++;
      setIn(9, 9, 0, 0, 0, 9, 1, 9, 1, 0); tick(0, 0, 2'b00, 0);
      checkCount("cnt_after_sr2");

      // Hazard under bus stall: no flush, forward held, no count.
      setIn(5, 0, 1, 0, 0, 0, 0, 5, 1, 0); tick(0, 0, 2'b01, 0);
      setIn(5, 0, 1, 0, 0, 5, 1, 5, 1, 1); tick(1, 0, 2'b01, 0);
      tick(1, 0, 2'b01, 0);
      checkCount("cnt_bus_hold");
      iBusStall = 1'b0; tick(1, 1, 2'b00, 0); hazCnt++;
      checkCount("cnt_bus_release");

      // Randomised RUN traffic against a reference model.
      mFwd = 2'b00;
      for (int i = 0; i < 40; i++) begin
         setIn(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 0, 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
         mHaz = ((iIdUsesSr1 && iIdSr1 == iExDest) || (iIdUsesSr2 && iIdSr2 == iExDest))
                && iExWritesReg && iExDest != 0;
         if (!iBusStall) begin
            if (mHaz) mFwd = 2'b00;
            else mFwd = {iIdUsesSr2 && iMemWritesReg && iMemDest != 0 && iIdSr2 == iMemDest,
                         iIdUsesSr1 && iMemWritesReg && iMemDest != 0 && iIdSr1 == iMemDest};
            if (mHaz) hazCnt++;
         end
         tick(iBusStall || mHaz, !iBusStall && mHaz, mFwd, 0);
      end
      checkCount("cnt_random");

      // HLT with hazard stalls first, then drains; two bus-stall cycles stretch the drain.
      setIn(3, 0, 1, 0, 1, 3, 1, 0, 0, 0); tick(1, 1, 2'b00, 0); hazCnt++;
      setIn(3, 0, 1, 0, 1, 0, 0, 0, 0, 0); tick(0, 0, 2'b00, 0);
      checkEq("state_drain", 16'(oState), 16'h1);
      setIn(3, 0, 1, 0, 0, 3, 1, 0, 0, 0); tick(1, 1, 2'b00, 0);
      iBusStall = 1'b1; tick(1, 0, 2'b00, 0); tick(1, 0, 2'b00, 0);
      iBusStall = 1'b0; tick(1, 1, 2'b00, 0);
      tick(1, 1, 2'b00, 1);
      tick(1, 1, 2'b00, 1);
      checkCount("cnt_halted");
      iBusStall = 1'b1; tick(1, 0, 2'b00, 1);

      // Reset out of HALTED leaves no residual stall.
      doReset();
      tick(0, 0, 2'b00, 0);
      // Reset mid-drain.
      setIn(0, 0, 0, 0, 1, 0, 0, 0, 0, 0); tick(0, 0, 2'b00, 0);
      iIdHalt = 1'b0; tick(1, 1, 2'b00, 0);
      doReset();
      tick(0, 0, 2'b00, 0);
      checkEq("state_run", 16'(oState), 16'h0);

`ifdef HAZ_STALL_CNT_EN
      setIn(3, 0, 1, 0, 0, 3, 1, 0, 0, 0);
      repeat (70000) @(posedge clk);
      #1;
`endif
      checkEq("cnt_saturate", oStallCount, CNT_EN ? 16'hFFFF : 16'h0000);
      doReset();
      checkEq("cnt_cleared", oStallCount, 16'h0000);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
